// File: rtl/lsq_unit.sv
// lsq_unit: circular load-store queue with in-order store drain and a memory FSM.
// Optional macro LSQ_FWD_EN enables youngest-older-store to load forwarding.
module lsq_unit #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_valid,
    input  logic                   alloc_is_store,
    input  logic [TAG_W-1:0]       alloc_tag,
    output logic                   alloc_ready,
    input  logic                   exe_valid,
    input  logic [TAG_W-1:0]       exe_tag,
    input  logic [ADDR_W-1:0]      exe_addr,
    input  logic [DATA_W-1:0]      exe_data,
    input  logic                   retire_valid,
    input  logic                   flush,
    output logic                   ld_done_valid,
    output logic [TAG_W-1:0]       ld_done_tag,
    output logic [DATA_W-1:0]      ld_done_data,
    output logic                   mem_req_valid,
    output logic                   mem_req_we,
    output logic [ADDR_W-1:0]      mem_req_addr,
    output logic [DATA_W-1:0]      mem_req_wdata,
    input  logic                   mem_req_ready,
    input  logic                   mem_resp_valid,
    input  logic [DATA_W-1:0]      mem_resp_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    typedef enum logic [2:0] {
        IDLE, ST_REQ, ST_WAIT, LD_REQ, LD_WAIT, LD_DROP
    } state_t;

    state_t state, state_nx;

    logic [DEPTH-1:0]  valid_q, store_q, av_q, done_q, cmt_q;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    // committed entries occupy [head, cptr); retire acts on cptr
    logic [PW-1:0] head, tail, cptr;
    logic [IW-1:0] hidx, tidx, cidx, ld_idx, idx, cand_idx;
    logic          full, head_cst, head_cld, ret_ok, ret_pop, st_pop, pop;
    logic          alloc_fire, cand_found, blocked, conflict;
    logic          fwd_hit, fwd_fire, ld_resp;
    logic [DATA_W-1:0] fwd_data;
`ifdef LSQ_FWD_EN
    logic [PW-1:0] cand_age;
    logic [IW-1:0] fdx;
`else
    logic [IW-1:0] jdx;
`endif

    assign hidx  = head[IW-1:0];
    assign tidx  = tail[IW-1:0];
    assign cidx  = cptr[IW-1:0];
    assign count = tail - head;
    assign empty = (count == '0);
    assign full  = (count == PW'(DEPTH));

    assign head_cst = valid_q[hidx] && cmt_q[hidx] && store_q[hidx];
    assign head_cld = valid_q[hidx] && cmt_q[hidx] && !store_q[hidx];
    assign ret_ok   = retire_valid && !flush && (cptr != tail) && valid_q[cidx]
                      && (store_q[cidx] ? av_q[cidx] : done_q[cidx]);
    assign ret_pop  = ret_ok && !store_q[cidx] && (cptr == head);
    assign st_pop   = (state == ST_WAIT) && mem_resp_valid;
    assign pop      = ret_pop || st_pop || head_cld;

    assign alloc_ready = !full || pop;
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;

    // oldest eligible load; an older store without an address stops the search
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        blocked    = 1'b0;
        conflict   = 1'b0;
        idx        = '0;
`ifdef LSQ_FWD_EN
        cand_age   = '0;
`else
        jdx        = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = hidx + IW'(i);
            if (PW'(i) < count && !cand_found && !blocked && valid_q[idx]) begin
                if (store_q[idx]) begin
                    if (!av_q[idx]) blocked = 1'b1;
                end else if (av_q[idx] && !done_q[idx]) begin
                    conflict = 1'b0;
`ifndef LSQ_FWD_EN
                    for (int j = 0; j < DEPTH; j++) begin
                        jdx = hidx + IW'(j);
                        if (j < i && store_q[jdx] && addr_q[jdx] == addr_q[idx])
                            conflict = 1'b1;
                    end
`endif
                    if (!conflict) begin
                        cand_found = 1'b1;
                        cand_idx   = idx;
`ifdef LSQ_FWD_EN
                        cand_age   = PW'(i);
`endif
                    end
                end
            end
        end
    end

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
`ifdef LSQ_FWD_EN
        fdx      = '0;
        for (int j = 0; j < DEPTH; j++) begin
            fdx = hidx + IW'(j);
            if (cand_found && PW'(j) < cand_age && store_q[fdx]
                && addr_q[fdx] == addr_q[cand_idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fdx];
            end
        end
`endif
    end

    assign fwd_fire = (state == IDLE) && !head_cst && cand_found && fwd_hit && !flush;
    assign ld_resp  = (state == LD_WAIT) && mem_resp_valid && !flush;

    always_comb begin
        state_nx      = state;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        unique case (state)
            IDLE: begin
                if (head_cst) state_nx = ST_REQ;
                else if (cand_found && !fwd_hit && !flush) state_nx = LD_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = addr_q[hidx];
                mem_req_wdata = data_q[hidx];
                if (mem_req_ready) state_nx = ST_WAIT;
            end
            ST_WAIT: if (mem_resp_valid) state_nx = IDLE;
            LD_REQ: begin
                mem_req_valid = !flush;
                mem_req_addr  = flush ? '0 : addr_q[ld_idx];
                if (flush) state_nx = IDLE;
                else if (mem_req_ready) state_nx = LD_WAIT;
            end
            LD_WAIT: begin
                if (mem_resp_valid) state_nx = IDLE;
                else if (flush) state_nx = LD_DROP;
            end
            LD_DROP: if (mem_resp_valid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_idx        <= '0;
            ld_done_valid <= 1'b0;
            ld_done_tag   <= '0;
            ld_done_data  <= '0;
        end else begin
            if (state == IDLE && state_nx == LD_REQ) ld_idx <= cand_idx;
            ld_done_valid <= fwd_fire || ld_resp;
            if (fwd_fire) begin
                ld_done_tag  <= tag_q[cand_idx];
                ld_done_data <= fwd_data;
            end else if (ld_resp) begin
                ld_done_tag  <= tag_q[ld_idx];
                ld_done_data <= mem_resp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            store_q <= '0;
            av_q    <= '0;
            done_q  <= '0;
            cmt_q   <= '0;
            head    <= '0;
            tail    <= '0;
            cptr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (fwd_fire) done_q[cand_idx] <= 1'b1;
            if (ld_resp)  done_q[ld_idx]   <= 1'b1;
            if (exe_valid && !flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && !cmt_q[i] && tag_q[i] == exe_tag) begin
                        addr_q[i] <= exe_addr;
                        av_q[i]   <= 1'b1;
                        if (store_q[i]) data_q[i] <= exe_data;
                    end
                end
            end
            if (ret_ok) begin
                cptr <= cptr + 1'b1;
                if (!ret_pop) cmt_q[cidx] <= 1'b1;
            end
            if (pop) begin
                valid_q[hidx] <= 1'b0;
                cmt_q[hidx]   <= 1'b0;
                head          <= head + 1'b1;
            end
            if (flush) begin
                for (int i = 0; i < DEPTH; i++)
                    if (!cmt_q[i]) valid_q[i] <= 1'b0;
                tail <= cptr;
            end else if (alloc_fire) begin
                valid_q[tidx] <= 1'b1;
                store_q[tidx] <= alloc_is_store;
                av_q[tidx]    <= 1'b0;
                done_q[tidx]  <= 1'b0;
                cmt_q[tidx]   <= 1'b0;
                tag_q[tidx]   <= alloc_tag;
                tail          <= tail + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lsq_unit.sv
// tb_lsq_unit: directed stimulus with scoreboard queues for load results and cache requests.
// Expectations follow LSQ_FWD_EN when it is defined.
module tb_lsq_unit;
    logic        clk, reset;
    logic        alloc_valid, alloc_is_store, alloc_ready;
    logic [5:0]  alloc_tag, exe_tag, ld_done_tag;
    logic        exe_valid, retire_valid, flush;
    logic [31:0] exe_addr, exe_data, ld_done_data;
    logic        ld_done_valid, mem_req_valid, mem_req_we, mem_req_ready;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
    logic        mem_resp_valid, empty;
    logic [4:0]  count;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] data;
    } ld_t;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    ld_t  exp_ld[$];
    req_t exp_req[$];
    logic [31:0] mem [logic [31:0]];

    int total = 0;
    int bad = 0;
    int nld = 0;
    int nreq = 0;
    int rdy_delay = 0;
    int resp_lat = 1;

    lsq_unit dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store),
        .alloc_tag(alloc_tag), .alloc_ready(alloc_ready),
        .exe_valid(exe_valid), .exe_tag(exe_tag),
        .exe_addr(exe_addr), .exe_data(exe_data),
        .retire_valid(retire_valid), .flush(flush),
        .ld_done_valid(ld_done_valid), .ld_done_tag(ld_done_tag),
        .ld_done_data(ld_done_data),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .count(count), .empty(empty)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    // load result monitor
    initial begin
        ld_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && ld_done_valid) begin
                nld++;
                if (exp_ld.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ld_unexpected: got tag %0h data %0h want none",
                             ld_done_tag, ld_done_data);
                end else begin
                    e = exp_ld.pop_front();
                    chk("ld_tag", ld_done_tag, e.tag);
                    chk("ld_data", ld_done_data, e.data);
                end
            end
        end
    end

    // request monitor: order, contents and stability while stalled
    initial begin
        req_t cur, prev, e;
        bit   pw;
        pw = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && mem_req_valid) begin
                cur = '{mem_req_we, mem_req_addr, mem_req_wdata};
                if (pw) chk("req_stable", cur, prev);
                if (mem_req_ready) begin
                    nreq++;
                    pw = 0;
                    if (exp_req.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL req_unexpected: got %0h want none", cur);
                    end else begin
                        e = exp_req.pop_front();
                        chk("req", cur, e);
                    end
                end else begin
                    pw = 1;
                    prev = cur;
                end
            end else begin
                pw = 0;
            end
        end
    end

    // cache model: one outstanding request, programmable ready stall and latency
    initial begin
        bit hs, busy, rwe;
        int lat, rwait;
        logic [31:0] ra, rd, rw;
        busy = 0; lat = 0; rwait = 0; rwe = 0; ra = 0; rd = 0; rw = 0;
        mem_req_ready = 0;
        mem_resp_valid = 0;
        mem_resp_data = '0;
        forever begin
            @(negedge clk);
            hs = mem_req_valid && mem_req_ready;
            if (hs) begin
                rwe = mem_req_we;
                ra = mem_req_addr;
                rw = mem_req_wdata;
            end
            @(posedge clk);
            #1;
            mem_resp_valid = 0;
            if (reset !== 1'b1) begin
                busy = 0;
                rwait = 0;
                mem_req_ready = 0;
            end else if (hs) begin
                busy = 1;
                lat = resp_lat;
                rwait = 0;
                mem_req_ready = 0;
                if (rwe) mem[ra] = rw;
                else rd = mem.exists(ra) ? mem[ra] : 32'h0;
            end else if (busy) begin
                lat--;
                if (lat <= 0) begin
                    mem_resp_valid = 1;
                    mem_resp_data = rwe ? 32'h0 : rd;
                    busy = 0;
                end
            end
            if (reset === 1'b1 && !busy && !hs) begin
                if (mem_req_valid) begin
                    if (rwait >= rdy_delay) mem_req_ready = 1;
                    else begin
                        rwait++;
                        mem_req_ready = 0;
                    end
                end else begin
                    rwait = 0;
                    mem_req_ready = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic st, input logic [5:0] t);
        alloc_valid = 1;
        alloc_is_store = st;
        alloc_tag = t;
        tick();
        alloc_valid = 0;
    endtask

    task automatic do_exe(input logic [5:0] t, input logic [31:0] a, input logic [31:0] d);
        exe_valid = 1;
        exe_tag = t;
        exe_addr = a;
        exe_data = d;
        tick();
        exe_valid = 0;
    endtask

    task automatic do_retire();
        retire_valid = 1;
        tick();
        retire_valid = 0;
    endtask

    task automatic push_ld(input logic [5:0] t, input logic [31:0] d);
        exp_ld.push_back('{t, d});
    endtask

    task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_req.push_back('{we, a, d});
    endtask

    task automatic wait_nld(input int n, input string nm);
        int c = 0;
        while (nld < n && c < 300) begin
            tick();
            c++;
        end
        chk(nm, nld, n);
    endtask

    task automatic wait_nreq(input int n, input string nm);
        int c = 0;
        while (nreq < n && c < 300) begin
            tick();
            c++;
        end
        chk(nm, nreq, n);
    endtask

    task automatic wait_empty(input string nm);
        int c = 0;
        while (!empty && c < 300) begin
            tick();
            c++;
        end
        chk(nm, empty, 1);
    endtask

    initial begin
        int b, r;
        reset = 0;
        alloc_valid = 0; alloc_is_store = 0; alloc_tag = 0;
        exe_valid = 0; exe_tag = 0; exe_addr = 0; exe_data = 0;
        retire_valid = 0; flush = 0;
        mem[32'h200] = 32'h1234;
        mem[32'h300] = 32'h3333;
        mem[32'h400] = 32'h55;
        mem[32'h600] = 32'h6666;
        repeat (3) tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_ld_done_valid", ld_done_valid, 0);
        chk("rst_ld_done_tag", ld_done_tag, 0);
        chk("rst_mem_req_addr", mem_req_addr, 0);
        @(negedge clk);
        reset = 1;
        tick();

        // store then load to the same address
        do_alloc(1, 6'd1);
        do_alloc(0, 6'd2);
        chk("t1_count", count, 2);
        push_ld(6'd2, 32'hDEAD);
        do_exe(6'd1, 32'h100, 32'hDEAD);
        do_exe(6'd2, 32'h100, 32'h0);
        repeat (4) tick();
`ifdef LSQ_FWD_EN
        chk("t1_fwd_done", nld, 1);
`else
        chk("t1_no_early_done", nld, 0);
`endif
        chk("t1_no_req_yet", nreq, 0);
        push_req(1, 32'h100, 32'hDEAD);
`ifndef LSQ_FWD_EN
        push_req(0, 32'h100, 32'h0);
`endif
        do_retire();
        wait_nld(1, "t1_ld_wait");
        do_retire();
        wait_empty("t1_empty");

        // cache read with stalled ready
        rdy_delay = 2;
        resp_lat = 3;
        b = nld;
        r = nreq;
        push_req(0, 32'h200, 32'h0);
        push_ld(6'd3, 32'h1234);
        do_alloc(0, 6'd3);
        do_exe(6'd3, 32'h200, 32'h0);
        wait_nld(b + 1, "t2_ld_wait");
        chk("t2_one_req", nreq, r + 1);
        do_retire();
        wait_empty("t2_empty");

        // full queue, rejected alloc, pop plus alloc
        rdy_delay = 0;
        resp_lat = 1;
        for (int i = 0; i < 16; i++) do_alloc(0, 6'(i));
        chk("t3_full_count", count, 16);
        chk("t3_full_ready", alloc_ready, 0);
        do_alloc(0, 6'd40);
        chk("t3_full_reject", count, 16);
        b = nld;
        push_req(0, 32'h400, 32'h0);
        push_ld(6'd0, 32'h55);
        do_exe(6'd0, 32'h400, 32'h0);
        wait_nld(b + 1, "t3_head_done");
        retire_valid = 1;
        alloc_valid = 1;
        alloc_is_store = 0;
        alloc_tag = 6'd16;
        #1;
        chk("t3_pop_ready", alloc_ready, 1);
        tick();
        retire_valid = 0;
        alloc_valid = 0;
        chk("t3_pop_alloc_count", count, 16);
        flush = 1;
        tick();
        flush = 0;
        chk("t3_flush_count", count, 0);

        // 40 allocations in pairs, pointers wrap
        for (int k = 0; k < 20; k++) begin
            b = nld;
            mem[32'h1000 + 8 * k] = 32'hA000 + 2 * k;
            mem[32'h1004 + 8 * k] = 32'hA001 + 2 * k;
            push_req(0, 32'h1000 + 8 * k, 32'h0);
            push_ld(6'(2 * k), 32'hA000 + 2 * k);
            push_req(0, 32'h1004 + 8 * k, 32'h0);
            push_ld(6'(2 * k + 1), 32'hA001 + 2 * k);
            do_alloc(0, 6'(2 * k));
            do_alloc(0, 6'(2 * k + 1));
            do_exe(6'(2 * k), 32'h1000 + 8 * k, 32'h0);
            do_exe(6'(2 * k + 1), 32'h1004 + 8 * k, 32'h0);
            wait_nld(b + 2, "t3_pair_done");
            do_retire();
            do_retire();
        end
        chk("t3_wrap_count", count, 0);

        // older store without address blocks the load
        b = nld;
        r = nreq;
        do_alloc(1, 6'd10);
        do_alloc(0, 6'd11);
        do_exe(6'd11, 32'h300, 32'h0);
        repeat (5) tick();
        chk("t4_blocked_ld", nld, b);
        chk("t4_blocked_req", nreq, r);
        push_req(0, 32'h300, 32'h0);
        push_ld(6'd11, 32'h3333);
        do_exe(6'd10, 32'h304, 32'hBEEF);
        wait_nld(b + 1, "t4_ld_wait");
        push_req(1, 32'h304, 32'hBEEF);
        do_retire();
        do_retire();
        wait_empty("t4_empty");

        // flush while a load waits for its response
        resp_lat = 8;
        b = nld;
        r = nreq;
        do_alloc(1, 6'd20);
        do_alloc(0, 6'd21);
        do_alloc(0, 6'd22);
        do_alloc(0, 6'd23);
        push_req(0, 32'h600, 32'h0);
        do_exe(6'd20, 32'h500, 32'h5555);
        do_exe(6'd21, 32'h600, 32'h0);
        wait_nreq(r + 1, "t5_ld_req");
        push_req(1, 32'h500, 32'h5555);
        do_retire();
        chk("t5_pre_flush_count", count, 4);
        flush = 1;
        tick();
        flush = 0;
        chk("t5_flush_count", count, 1);
        wait_empty("t5_empty");
        chk("t5_store_written", mem[32'h500], 32'h5555);
        chk("t5_no_ld_done", nld, b);

        // reset while a store is requesting
        resp_lat = 1;
        rdy_delay = 100;
        do_alloc(1, 6'd30);
        do_exe(6'd30, 32'h700, 32'h77);
        do_retire();
        begin
            int c = 0;
            while (!mem_req_valid && c < 20) begin
                tick();
                c++;
            end
        end
        chk("t6_st_req", {mem_req_valid, mem_req_we}, 2'b11);
        #2;
        reset = 0;
        #1;
        chk("t6_req_drop", mem_req_valid, 0);
        chk("t6_count", count, 0);
        chk("t6_empty", empty, 1);
        chk("t6_ready", alloc_ready, 1);
        @(negedge clk);
        reset = 1;
        rdy_delay = 0;
        tick();

        // normal operation after reset
        b = nld;
        push_req(0, 32'h200, 32'h0);
        push_ld(6'd5, 32'h1234);
        do_alloc(0, 6'd5);
        do_exe(6'd5, 32'h200, 32'h0);
        wait_nld(b + 1, "t6_recover_ld");
        do_retire();
        wait_empty("t6_recover_empty");
        repeat (4) tick();

        chk("exp_ld_left", exp_ld.size(), 0);
        chk("exp_req_left", exp_req.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsq_unit.md
Name: lsq_unit

Overview:
Parametrised circular load-store queue for the memory stage.
- Allocates entries in program order at dispatch and captures address/data from execute.
- Resolves loads by youngest-older-store forwarding or a cache read, and returns load results with their tag.
- Drains retired stores to the data cache in order through a single request/response port.
- Replaces the combinational LSQ search in the memory stage with a sequenced queue plus memory FSM.

Parameters:
DEPTH, 16, queue entries (power of 2, >=2)
ADDR_W, 32, address width
DATA_W, 32, data width
TAG_W, 6, ROB tag width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
alloc_valid  in  1  dispatch requests an entry
alloc_is_store  in  1  1=store, 0=load
alloc_tag  in  TAG_W  ROB tag of new entry
alloc_ready  out  1  not full; an allocation is taken only when alloc_valid&&alloc_ready
exe_valid  in  1  execute delivers address (and store data)
exe_tag  in  TAG_W  tag to match
exe_addr  in  ADDR_W  effective address
exe_data  in  DATA_W  store data (ignored for loads)
retire_valid  in  1  ROB retires the LSQ head entry this cycle
flush  in  1  discard all uncommitted entries
ld_done_valid  out  1  load result pulse
ld_done_tag  out  TAG_W  tag of completed load
ld_done_data  out  DATA_W  load value
mem_req_valid  out  1  cache request
mem_req_we  out  1  1=write
mem_req_addr  out  ADDR_W  request address
mem_req_wdata  out  DATA_W  write data
mem_req_ready  in  1  cache accepts request
mem_resp_valid  in  1  read data / write ack
mem_resp_data  in  DATA_W  read data
count  out  $clog2(DEPTH)+1  occupied entries
empty  out  1  count==0

Behaviour:
- Entry fields:
  - valid, is_store, tag, addr_valid, addr, data, done, committed.
- Pointers:
  - head/tail of $clog2(DEPTH)+1 bits; wrap bit distinguishes full from empty.
  - Age is position relative to head.
- Reset (asynchronous, reset low): all valid=0; head=tail=0; count=0; empty=1; alloc_ready=1; FSM=IDLE; ld_done_valid=0; mem_req_valid=0; all data outputs 0.
- Allocate: written at tail; tail+1 on the next edge. With a full queue, alloc_ready=0 and nothing is written.
- Execute: a matching valid entry latches addr (and data if store) and sets addr_valid.
  - A non-matching tag is ignored.
  - Execute of an entry allocated in the same cycle is not supported.
- Load candidate: oldest valid load with addr_valid && !done, and every older store has addr_valid.
- Load resolution, with the FSM in IDLE and no committed store at head:
  - Forward: the youngest older store with an equal address supplies data.
  - Result: ld_done_* pulses 1 cycle after the candidate qualifies; done is set.
  - No match: FSM issues a read.
- Retire: the head entry must have done=1 (load) or addr_valid=1 (store). Retire of an unqualified head is an error and is ignored.
  - Load head: popped on the next edge.
  - Store head: committed=1 and stays queued until written.
- Memory FSM:
  - IDLE -> ST_REQ when the head is a committed store. Stores have priority over loads.
  - IDLE -> LD_REQ when a load candidate has no forward.
  - ST_REQ: mem_req_valid=1, we=1, head addr/data held stable until mem_req_ready -> ST_WAIT.
  - ST_WAIT: on mem_resp_valid, pop head -> IDLE.
  - LD_REQ: mem_req_valid=1, we=0 until ready -> LD_WAIT.
  - LD_WAIT: on mem_resp_valid, pulse ld_done_* with mem_resp_data, set done -> IDLE.
  - Exactly one outstanding request at a time.
- Flush:
  - Invalidates every uncommitted entry on the next edge; tail = index after the last committed store.
  - Committed stores continue draining.
  - If flush lands in LD_REQ: drop the request -> IDLE.
  - If flush lands in LD_WAIT: go to LD_DROP and discard the next response, then IDLE. No ld_done pulse.
  - Flush has priority over a same-cycle alloc, exe or retire of uncommitted entries.
- Simultaneous alloc and pop: count is unchanged; full remains correct at DEPTH.
- Pointer wrap: pointers wrap modulo 2*DEPTH; search order follows age, not index.
- Reset mid-operation: immediate return to reset state; any outstanding response is ignored.

Optional Feature:
LSQ_FWD_EN
- Defined: store-to-load forwarding as above.
- Undefined: a load whose address matches any older queued store is not a candidate until that store pops. All load data then comes from the cache.

Test Plan:
- Alloc store tag 1 then load tag 2; exe tag 1 addr 0x100 data 0xDEAD; exe tag 2 addr 0x100 -> ld_done tag 2 data 0xDEAD with no mem_req (with LSQ_FWD_EN). Without LSQ_FWD_EN: no ld_done until the store is retired and written.
- Load tag 3 addr 0x200, cache returns 0x1234 after 3 cycles with ready held low for 2 cycles -> one read request, held stable while ready is low, then ld_done tag 3 data 0x1234.
- Alloc 16 entries -> alloc_ready=0 and count=16; retire/pop one and alloc in the same cycle -> count stays 16; 40 allocs with pops -> wrap-around order preserved.
- Older store with unresolved address; younger load exe addr 0x300 -> no ld_done until the store exe arrives. Store at 0x304 -> load goes to cache.
- Committed store plus 3 uncommitted entries, flush during a load in LD_WAIT -> count=1, response discarded, store still written, no ld_done.
- Assert reset mid ST_REQ -> mem_req_valid=0 the same cycle, count=0, empty=1.
